// File: rtl/regfile_pkg.sv
// regfile_pkg: shared constants, address-width helper and read-address vector type for the register file
package regfile_pkg;

  localparam int XLEN_DEF        = 32;
  localparam int NREGS_DEF       = 32;
  localparam int NREAD_DEF       = 2;
  localparam int LINK_REG_DEF    = 31;
  localparam int UPPER_SHIFT_DEF = 16;
  localparam int LED_REG_DEF     = 23;

  function automatic int aw_of(input int nregs);
    return $clog2(nregs);
  endfunction

  localparam int AW_DEF = aw_of(NREGS_DEF);

  typedef logic [NREAD_DEF*AW_DEF-1:0] raddr_vec_t;

endpackage

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: per-register busy bits tracking outstanding writes from issued instructions
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int NREGS    = NREGS_DEF,
  parameter int ZERO_REG = 1,
  parameter int LINK_REG = LINK_REG_DEF,
  localparam int AW      = aw_of(NREGS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wren,
  input  logic [AW-1:0]    waddr,
  input  logic             link_wren,
  input  logic             issue_valid,
  input  logic [AW-1:0]    issue_addr,
  output logic [NREGS-1:0] busy,
  output logic             busy_any
);

  localparam logic [AW-1:0] LINK_A = AW'(LINK_REG);

  logic [NREGS-1:0] busy_nxt;

  // clears first, then issue set so a same-cycle new producer keeps the bit
  always_comb begin
    busy_nxt = busy;
    if (wren) busy_nxt[waddr] = 1'b0;
    if (link_wren) busy_nxt[LINK_A] = 1'b0;
    if (issue_valid) busy_nxt[issue_addr] = 1'b1;
    if (ZERO_REG != 0) busy_nxt[0] = 1'b0;
  end

  // busy vector register, wiped on reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy <= '0;
    else busy <= busy_nxt;
  end

  assign busy_any = |busy;

endmodule

// File: rtl/regfile_sb.sv
// regfile_sb: parametrised register file with write bypass, link port, upper-immediate writes and busy scoreboard
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int XLEN        = XLEN_DEF,
  parameter int NREGS       = NREGS_DEF,
  parameter int NREAD       = NREAD_DEF,
  parameter int ZERO_REG    = 1,
  parameter int LINK_REG    = LINK_REG_DEF,
  parameter int UPPER_SHIFT = UPPER_SHIFT_DEF,
  parameter int LED_REG     = LED_REG_DEF,
  localparam int AW         = aw_of(NREGS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREAD*AW-1:0]   raddr,
  output logic [NREAD*XLEN-1:0] rdata,
  output logic [NREAD-1:0]      rbusy,
  input  logic [AW-1:0]         waddr,
  input  logic [XLEN-1:0]       wdata,
  input  logic                  wren,
  input  logic                  is_upper,
  input  logic                  link_wren,
  input  logic [XLEN-1:0]       link_data,
  input  logic                  issue_valid,
  input  logic [AW-1:0]         issue_addr,
  output logic                  busy_any,
  input  logic [AW-1:0]         dbg_addr,
  output logic [XLEN-1:0]       dbg_data,
  output logic [XLEN-1:0]       ledr_out
);

  localparam logic [AW-1:0] LINK_A = AW'(LINK_REG);
  localparam logic [AW-1:0] LED_A  = AW'(LED_REG);

  logic [XLEN-1:0]  regs [NREGS];
  logic [XLEN-1:0]  wv;
  logic [NREGS-1:0] busy;
  logic             w_ok;
  logic             link_ok;

  assign wv      = is_upper ? (wdata << UPPER_SHIFT) : wdata;
  assign w_ok    = wren && !(ZERO_REG != 0 && waddr == '0);
  assign link_ok = link_wren && !(ZERO_REG != 0 && LINK_A == '0);

  // storage; link write is last so it overrides a colliding writeback
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else begin
      if (w_ok) regs[waddr] <= wv;
      if (link_ok) regs[LINK_A] <= link_data;
    end
  end

  regfile_scoreboard #(
    .NREGS   (NREGS),
    .ZERO_REG(ZERO_REG),
    .LINK_REG(LINK_REG)
  ) u_sb (
    .clk        (clk),
    .rst_n      (rst_n),
    .wren       (wren),
    .waddr      (waddr),
    .link_wren  (link_wren),
    .issue_valid(issue_valid),
    .issue_addr (issue_addr),
    .busy       (busy),
    .busy_any   (busy_any)
  );

  for (genvar g = 0; g < NREAD; g++) begin : g_rd
    logic [AW-1:0] ra;
    logic          zero_hit;
    logic          link_hit;
    logic          w_hit;
    assign ra       = raddr[g*AW +: AW];
    assign zero_hit = ZERO_REG != 0 && ra == '0;
    assign link_hit = link_wren && ra == LINK_A;
    assign w_hit    = wren && ra == waddr;
    assign rdata[g*XLEN +: XLEN] = zero_hit ? '0 : link_hit ? link_data : w_hit ? wv : regs[ra];
    assign rbusy[g] = busy[ra] & ~(link_hit | w_hit);
  end

  assign dbg_data = regs[dbg_addr];
  assign ledr_out = regs[LED_A];

endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb: directed checks of bypass, link priority, zero register, scoreboard, LED tap and async reset
module tb_regfile_sb;
  import regfile_pkg::*;

  logic            clk = 1'b0;
  logic            rst_n;
  raddr_vec_t      raddr;
  logic [63:0]     rdata;
  logic [1:0]      rbusy;
  logic [4:0]      waddr;
  logic [31:0]     wdata;
  logic            wren;
  logic            is_upper;
  logic            link_wren;
  logic [31:0]     link_data;
  logic            issue_valid;
  logic [4:0]      issue_addr;
  logic            busy_any;
  logic [4:0]      dbg_addr;
  logic [31:0]     dbg_data;
  logic [31:0]     ledr_out;

  int n_tests = 0;
  int n_fail  = 0;

  regfile_sb dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .raddr      (raddr),
    .rdata      (rdata),
    .rbusy      (rbusy),
    .waddr      (waddr),
    .wdata      (wdata),
    .wren       (wren),
    .is_upper   (is_upper),
    .link_wren  (link_wren),
    .link_data  (link_data),
    .issue_valid(issue_valid),
    .issue_addr (issue_addr),
    .busy_any   (busy_any),
    .dbg_addr   (dbg_addr),
    .dbg_data   (dbg_data),
    .ledr_out   (ledr_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic idle();
    wren = 0; is_upper = 0; waddr = '0; wdata = '0;
    link_wren = 0; link_data = '0;
    issue_valid = 0; issue_addr = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 0; raddr = '0; dbg_addr = '0;
    idle();
    #12;
    check("reset_rdata", rdata[31:0], 32'h0);
    check("reset_busy_any", 32'(busy_any), 32'h0);
    check("reset_led", ledr_out, 32'h0);
    rst_n = 1;
    tick();

    // upper-immediate write with same-cycle bypass
    wren = 1; is_upper = 1; waddr = 3; wdata = 32'h0000_1234; raddr[4:0] = 3;
    #1 check("upper_bypass", rdata[31:0], 32'h1234_0000);
    tick(); idle();
    dbg_addr = 3; raddr[9:5] = 3; raddr[4:0] = 0;
    #1 check("upper_dbg", dbg_data, 32'h1234_0000);
    check("port1_stored", rdata[63:32], 32'h1234_0000);

    // plain write, read bypass then stored
    wren = 1; waddr = 12; wdata = 32'hCAFE_0012; raddr[9:5] = 12;
    #1 check("plain_bypass_p1", rdata[63:32], 32'hCAFE_0012);
    check("plain_dbg_before", dbg_data, 32'h1234_0000);
    tick(); idle();
    dbg_addr = 12;
    #1 check("plain_dbg_after", dbg_data, 32'hCAFE_0012);

    // link and writeback collide on r31
    wren = 1; waddr = 31; wdata = 32'h11; link_wren = 1; link_data = 32'h400; raddr[4:0] = 31;
    #1 check("link_bypass", rdata[31:0], 32'h400);
    tick(); idle();
    dbg_addr = 31;
    #1 check("link_wins", dbg_data, 32'h400);

    // link and writeback to different registers both commit
    wren = 1; waddr = 4; wdata = 32'h44; link_wren = 1; link_data = 32'h800;
    tick(); idle();
    dbg_addr = 4;
    #1 check("both_r4", dbg_data, 32'h44);
    dbg_addr = 31;
    #1 check("both_r31", dbg_data, 32'h800);

    // zero register ignores write and issue
    wren = 1; waddr = 0; wdata = 32'hFFFF_FFFF; issue_valid = 1; issue_addr = 0; raddr[4:0] = 0;
    #1 check("zero_bypass", rdata[31:0], 32'h0);
    tick(); idle();
    dbg_addr = 0;
    #1 check("zero_dbg", dbg_data, 32'h0);
    check("zero_busy_any", 32'(busy_any), 32'h0);

    // scoreboard hazard on r7
    issue_valid = 1; issue_addr = 7;
    tick(); idle();
    raddr[4:0] = 7;
    #1 check("haz_rbusy", 32'(rbusy[0]), 32'h1);
    check("haz_busy_any", 32'(busy_any), 32'h1);
    tick(); tick(); tick();
    check("haz_hold", 32'(rbusy[0]), 32'h1);
    wren = 1; waddr = 7; wdata = 32'h55;
    #1 check("haz_resolve_rbusy", 32'(rbusy[0]), 32'h0);
    check("haz_resolve_rdata", rdata[31:0], 32'h55);
    check("haz_busy_any_reg", 32'(busy_any), 32'h1);
    tick(); idle();
    check("haz_cleared", 32'(rbusy[0]), 32'h0);
    check("haz_any_cleared", 32'(busy_any), 32'h0);

    // link write clears busy on r31
    issue_valid = 1; issue_addr = 31;
    tick(); idle();
    raddr[4:0] = 31;
    #1 check("link_busy_set", 32'(rbusy[0]), 32'h1);
    link_wren = 1; link_data = 32'h900;
    #1 check("link_busy_mask", 32'(rbusy[0]), 32'h0);
    tick(); idle();
    check("link_busy_clr", 32'(busy_any), 32'h0);

    // same-cycle write and issue on r9 keeps it busy
    wren = 1; waddr = 9; wdata = 32'h99; issue_valid = 1; issue_addr = 9;
    tick(); idle();
    raddr[9:5] = 9;
    #1 check("setclr_busy", 32'(rbusy[1]), 32'h1);
    check("setclr_data", rdata[63:32], 32'h99);
    wren = 1; waddr = 9; wdata = 32'h9A;
    tick(); idle();
    check("setclr_done", 32'(busy_any), 32'h0);

    // LED tap is raw storage, no bypass
    wren = 1; waddr = 23; wdata = 32'hA5;
    #1 check("led_before", ledr_out, 32'h0);
    tick(); idle();
    check("led_after", ledr_out, 32'hA5);

    // asynchronous reset mid-operation
    wren = 1; waddr = 5; wdata = 32'hDEAD_BEEF; issue_valid = 1; issue_addr = 5;
    tick(); idle();
    raddr[4:0] = 5;
    #1 check("pre_rst_data", rdata[31:0], 32'hDEAD_BEEF);
    check("pre_rst_busy", 32'(rbusy[0]), 32'h1);
    issue_valid = 1; issue_addr = 6; wren = 1; waddr = 8; wdata = 32'h88;
    #1 rst_n = 0;
    #1 check("rst_rdata", rdata[31:0], 32'h0);
    check("rst_rbusy", 32'(rbusy[0]), 32'h0);
    check("rst_busy_any", 32'(busy_any), 32'h0);
    check("rst_led", ledr_out, 32'h0);
    idle();
    #1 rst_n = 1;
    tick();
    dbg_addr = 8;
    #1 check("rst_no_partial", dbg_data, 32'h0);
    check("rst_busy_after", 32'(busy_any), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
- Parametrised general-purpose register file for the CPU core; successor to the fixed 32x32, two-read-port file.
- Adds configurable width, depth and read-port count, plus an optional hardwired-zero register.
- Adds write-to-read bypass and a per-register busy scoreboard, so decode can detect hazards on outstanding multi-cycle writes.
- Keeps the upper-immediate write mode, the dedicated link-register write port, and the debug and LED taps.
- Sits between decode (read, issue) and writeback (write, link).

Parameters:
- XLEN, 32, data width in bits.
- NREGS, 32, number of registers (power of two, at least 4); AW = log2(NREGS).
- NREAD, 2, number of combinational read ports (1..4).
- ZERO_REG, 1, when 1 register 0 always reads 0, ignores writes and is never busy.
- LINK_REG, 31, index written by the link port.
- UPPER_SHIFT, 16, left-shift applied to wdata when is_upper=1.
- LED_REG, 23, index driven on ledr_out.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- raddr  in  NREAD*AW  packed read addresses; port i is bits [i*AW +: AW]
- rdata  out  NREAD*XLEN  packed read data, with bypass
- rbusy  out  NREAD  register addressed by port i has a pending write
- waddr  in  AW  writeback address
- wdata  in  XLEN  writeback data
- wren  in  1  writeback enable
- is_upper  in  1  store (wdata << UPPER_SHIFT), truncated to XLEN
- link_wren  in  1  link write enable
- link_data  in  XLEN  link value (return address)
- issue_valid  in  1  decode issued an instruction that will write issue_addr
- issue_addr  in  AW  destination of the issued instruction
- busy_any  out  1  OR of all busy bits
- dbg_addr  in  AW  debug read address
- dbg_data  out  XLEN  raw register contents, no bypass
- ledr_out  out  XLEN  raw contents of LED_REG

Behaviour:
- Reset: asserting rst_n low immediately clears all registers and all busy bits to 0. Consequently rdata, dbg_data and ledr_out read 0, and rbusy and busy_any read 0. Reset may assert mid-write or mid-issue; no partial state survives.
- Write value: wv = is_upper ? (wdata << UPPER_SHIFT) : wdata, computed in XLEN bits with upper bits dropped.
- Writes commit at the rising edge of clk.
- If wren and link_wren both target LINK_REG in the same cycle, link_data wins. Writes to different addresses both commit.
- Zero register (ZERO_REG=1): writes to register 0 are dropped; reads return 0; issue to register 0 is ignored.
- Read ports are combinational, zero latency. Bypass priority per port:
  1. zero register, returns 0;
  2. link_wren with raddr==LINK_REG, returns link_data;
  3. wren with raddr==waddr, returns wv;
  4. otherwise the stored value.
- Scoreboard: one busy bit per register. At each edge, in ascending priority:
  - busy[waddr] is cleared if wren;
  - busy[LINK_REG] is cleared if link_wren;
  - busy[issue_addr] is set if issue_valid.
- Same-cycle issue and write to the same address leaves the bit set: the new producer wins.
- rbusy[i] = busy[raddr_i] AND NOT (a bypass write this cycle hits raddr_i, per priorities 2 and 3). A write arriving this cycle therefore resolves the hazard without a stall.
- Issue to an already-busy register keeps it busy. There is no counting, since only one outstanding producer per register is supported.
- busy_any is the registered-state OR, with no bypass masking.
- Any unused packed-port bits are not permitted; every port i in 0..NREAD-1 is live.

Decomposition:
- Package regfile_pkg holds:
  - the AW computation function;
  - default constants (XLEN_DEF, LINK_REG_DEF, UPPER_SHIFT_DEF);
  - a typedef for a packed read-address vector.
- Sub-module regfile_scoreboard holds the busy vector and its set/clear logic. It outputs busy[] and busy_any; rbusy masking stays in the top level.
- Storage, write-value generation and bypass muxing live in regfile_sb.

Test Plan:
- Reset mid-operation: write 0xDEADBEEF to r5, issue r5, pulse rst_n low between edges -> rdata for r5 = 0 immediately, rbusy=0, busy_any=0.
- Upper write and bypass: wren=1, is_upper=1, waddr=3, wdata=0x00001234, raddr0=3 -> rdata0=0x12340000 the same cycle; after the edge, dbg_data at r3 = 0x12340000.
- Link conflict: same cycle wren waddr=31 wdata=0x11 and link_wren link_data=0x400 -> r31 = 0x400, port 0 reading r31 shows 0x400 during that cycle.
- Zero register: write 0xFFFFFFFF to r0, issue r0 -> r0 reads 0, busy_any stays 0.
- Scoreboard hazard: issue r7 -> next cycle rbusy0=1 at raddr0=7. Wait 3 cycles, then wren r7 = 0x55 -> rbusy0=0 and rdata0=0x55 in the write cycle; busy clears after the edge.
- Same-cycle set/clear and LED tap: wren r9 with issue r9 -> busy[9] remains 1. Write 0xA5 to r23 -> ledr_out=0xA5 after the edge.
